// File: rtl/dcache_store_port.sv
// Commit-store buffer on the data-cache side. It queues retired stores in order, drains them
// to memory over a req/ack handshake, and flags loads that hit a word still buffered.
module dcache_store_port #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dcache_write,
  input  logic [3:0]            dcache_mask,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [DATA_WIDTH-1:0] dcache_data,
  output logic                  dcache_write_valid,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_hazard,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_mask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic                  drained
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned WordW = ADDR_WIDTH - 2;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic [WordW-1:0]        addr_mem [DEPTH];
  logic [3:0]              mask_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [PtrW-1:0]         rd_ptr_q;
  logic [PtrW-1:0]         wr_ptr_q;
  logic [CntW-1:0]         count_q;
  logic [CntW-1:0]         count_d;
  logic                    push;
  logic                    pop;

  // Depends on registered count only, so a same-cycle pop never frees the slot.
  assign dcache_write_valid = (count_q != FullCnt);
  assign push = dcache_write && dcache_write_valid && (dcache_mask != 4'b0000);
  assign pop  = (state_q == StBusy) && mem_ack;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (pop && (count_d == '0)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Payload storage needs no reset: only entries inside the count window are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= dcache_addr[ADDR_WIDTH-1:2];
      mask_mem[wr_ptr_q] <= dcache_mask;
      data_mem[wr_ptr_q] <= dcache_data;
    end
  end

  assign mem_req   = (state_q == StBusy);
  assign mem_addr  = {addr_mem[rd_ptr_q], 2'b00};
  assign mem_mask  = mask_mem[rd_ptr_q];
  assign mem_wdata = data_mem[rd_ptr_q];
  assign drained   = (count_q == '0) && (state_q == StIdle);

  // An entry is live when its distance from the head is below the occupancy count.
  always_comb begin
    logic [PtrW-1:0] offset;
    ld_hazard = 1'b0;
    offset    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PtrW'(i) - rd_ptr_q;
      if (ld_req && ({1'b0, offset} < count_q) &&
          (addr_mem[i] == ld_addr[ADDR_WIDTH-1:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_store_port.sv
// Bench for dcache_store_port: directed scenarios plus a randomized run checked against a
// queue-based model of the store buffer.
module tb_dcache_store_port;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dcache_write = 1'b0;
  logic [3:0]  dcache_mask = '0;
  logic [31:0] dcache_addr = '0;
  logic [31:0] dcache_data = '0;
  logic        dcache_write_valid;
  logic        ld_req = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hazard;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        drained;

  int checks = 0;
  int failures = 0;

  // Model: pending stores in commit order, plus whether a memory request is outstanding.
  logic [31:0] mq_addr[$];
  logic [3:0]  mq_mask[$];
  logic [31:0] mq_data[$];
  bit          m_req = 1'b0;

  dcache_store_port #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .dcache_write(dcache_write), .dcache_mask(dcache_mask), .dcache_addr(dcache_addr),
    .dcache_data(dcache_data), .dcache_write_valid(dcache_write_valid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_mask(mem_mask), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int unsigned sz;
    bit do_pop, do_push;
    if (rst) begin
      mq_addr.delete(); mq_mask.delete(); mq_data.delete();
      m_req = 1'b0;
    end else begin
      sz      = mq_addr.size();
      do_pop  = m_req && mem_ack;
      do_push = dcache_write && (sz != DEPTH) && (dcache_mask != 4'b0);
      if (do_pop) begin
        void'(mq_addr.pop_front()); void'(mq_mask.pop_front()); void'(mq_data.pop_front());
      end
      if (do_push) begin
        mq_addr.push_back(dcache_addr & 32'hFFFF_FFFC);
        mq_mask.push_back(dcache_mask);
        mq_data.push_back(dcache_data);
      end
      if (m_req) m_req = do_pop ? (mq_addr.size() != 0) : 1'b1;
      else       m_req = (sz != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dcache_write = 1'b0; dcache_mask = '0; dcache_addr = '0; dcache_data = '0;
    ld_req = 1'b0; ld_addr = '0; mem_ack = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    dcache_write = 1'b1; dcache_mask = m; dcache_addr = a; dcache_data = d;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ld_req = 1'b1; ld_addr = 32'h0;
    #1;
    checks += 4;
    if (dcache_write_valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%b exp=1", dcache_write_valid); end
    if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    if (ld_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", ld_hazard); end
    if (drained !== 1'b1) begin failures++; $display("FAIL reset_drained got=%b exp=1", drained); end
    idle();
  endtask

  task automatic test_single();
    store(32'h1001, 4'b0010, 32'h0000_AB00);
    tick();
    idle();
    checks += 2;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL single_req_early got=%b exp=0", mem_req); end
    if (drained !== 1'b0) begin failures++; $display("FAIL single_drained_busy got=%b exp=0", drained); end
    tick();
    checks += 4;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL single_req got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h1000) begin failures++; $display("FAIL single_addr got=%h exp=00001000", mem_addr); end
    if (mem_mask !== 4'b0010) begin failures++; $display("FAIL single_mask got=%b exp=0010", mem_mask); end
    if (mem_wdata !== 32'h0000_AB00) begin failures++; $display("FAIL single_data got=%h exp=0000ab00", mem_wdata); end
    tick();
    checks += 2;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL single_hold_req got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h1000) begin failures++; $display("FAIL single_hold_addr got=%h exp=00001000", mem_addr); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks += 2;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL single_req_done got=%b exp=0", mem_req); end
    if (drained !== 1'b1) begin failures++; $display("FAIL single_drained got=%b exp=1", drained); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 4'hF, 32'h100 + 32'(i));
      tick();
    end
    idle();
    checks++;
    if (dcache_write_valid !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", dcache_write_valid); end
    store(32'h40, 4'hF, 32'hDEAD);
    tick();
    idle();
    checks++;
    if (dcache_write_valid !== 1'b0) begin failures++; $display("FAIL fill_held got=%b exp=0", dcache_write_valid); end
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      checks += 3;
      if (mem_req !== 1'b1) begin failures++; $display("FAIL fill_req[%0d] got=%b exp=1", i, mem_req); end
      if (mem_addr !== 32'h10 + 32'(4 * i)) begin
        failures++; $display("FAIL fill_addr[%0d] got=%h exp=%h", i, mem_addr, 32'h10 + 32'(4 * i));
      end
      if (mem_wdata !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL fill_data[%0d] got=%h exp=%h", i, mem_wdata, 32'h100 + 32'(i));
      end
      tick();
      if (i == 0) begin
        checks++;
        if (dcache_write_valid !== 1'b1) begin failures++; $display("FAIL fill_valid_after_ack got=%b exp=1", dcache_write_valid); end
      end
    end
    mem_ack = 1'b0;
    checks += 2;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL fill_req_done got=%b exp=0", mem_req); end
    if (drained !== 1'b1) begin failures++; $display("FAIL fill_drained got=%b exp=1", drained); end
  endtask

  task automatic test_simultaneous();
    store(32'h30, 4'hF, 32'h30); tick();
    store(32'h34, 4'hF, 32'h34); tick();
    idle();
    checks += 2;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL simul_req got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h30) begin failures++; $display("FAIL simul_head got=%h exp=00000030", mem_addr); end
    store(32'h38, 4'hF, 32'h38);
    mem_ack = 1'b1;
    tick();
    idle();
    checks += 2;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL simul_req_kept got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h34) begin failures++; $display("FAIL simul_next got=%h exp=00000034", mem_addr); end
    mem_ack = 1'b1;
    tick();
    checks += 2;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL simul_req_last got=%b exp=1", mem_req); end
    if (mem_addr !== 32'h38) begin failures++; $display("FAIL simul_last got=%h exp=00000038", mem_addr); end
    tick();
    mem_ack = 1'b0;
    checks++;
    if (drained !== 1'b1) begin failures++; $display("FAIL simul_drained got=%b exp=1", drained); end
  endtask

  task automatic test_hazard();
    store(32'h2003, 4'b1000, 32'hAA00_0000);
    tick();
    idle();
    ld_req = 1'b1; ld_addr = 32'h2000; #1;
    checks++;
    if (ld_hazard !== 1'b1) begin failures++; $display("FAIL hazard_hit got=%b exp=1", ld_hazard); end
    ld_addr = 32'h2004; #1;
    checks++;
    if (ld_hazard !== 1'b0) begin failures++; $display("FAIL hazard_miss got=%b exp=0", ld_hazard); end
    store(32'h3000, 4'b0001, 32'h55);
    ld_addr = 32'h3000; #1;
    checks++;
    if (ld_hazard !== 1'b0) begin failures++; $display("FAIL hazard_same_cycle got=%b exp=0", ld_hazard); end
    tick();
    dcache_write = 1'b0; dcache_mask = '0;
    ld_addr = 32'h3001; #1;
    checks++;
    if (ld_hazard !== 1'b1) begin failures++; $display("FAIL hazard_second got=%b exp=1", ld_hazard); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    ld_addr = 32'h2000; #1;
    checks++;
    if (ld_hazard !== 1'b0) begin failures++; $display("FAIL hazard_after_ack got=%b exp=0", ld_hazard); end
    mem_ack = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_zero_mask();
    store(32'h500, 4'b0000, 32'h1234);
    #1;
    checks++;
    if (dcache_write_valid !== 1'b1) begin failures++; $display("FAIL zmask_valid got=%b exp=1", dcache_write_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL zmask_req[%0d] got=%b exp=0", i, mem_req); end
      if (drained !== 1'b1) begin failures++; $display("FAIL zmask_drained[%0d] got=%b exp=1", i, drained); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      store(32'h60 + 32'(4 * i), 4'hF, 32'(i)); tick();
    end
    idle();
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_req_before got=%b exp=1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 3;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%b exp=0", mem_req); end
    if (drained !== 1'b1) begin failures++; $display("FAIL rstmid_drained got=%b exp=1", drained); end
    if (dcache_write_valid !== 1'b1) begin failures++; $display("FAIL rstmid_valid got=%b exp=1", dcache_write_valid); end
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_stale[%0d] got=%b exp=0", i, mem_req); end
    end
    idle();
  endtask

  task automatic test_random();
    bit exp_hz;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      dcache_write = $urandom_range(0, 1);
      dcache_mask  = ($urandom_range(0, 7) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      dcache_addr  = 32'h8000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      dcache_data  = $urandom;
      mem_ack      = ($urandom_range(0, 9) < 4);
      ld_req       = $urandom_range(0, 1);
      ld_addr      = 32'h8000 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
      #1;
      exp_hz = 1'b0;
      foreach (mq_addr[k]) if (ld_req && (mq_addr[k] == (ld_addr & 32'hFFFF_FFFC))) exp_hz = 1'b1;
      checks += 4;
      if (dcache_write_valid !== (mq_addr.size() != DEPTH)) begin
        failures++; $display("FAIL rand_valid n=%0d got=%b exp=%b", n, dcache_write_valid, mq_addr.size() != DEPTH);
      end
      if (mem_req !== m_req) begin failures++; $display("FAIL rand_req n=%0d got=%b exp=%b", n, mem_req, m_req); end
      if (drained !== (mq_addr.size() == 0 && !m_req)) begin
        failures++; $display("FAIL rand_drained n=%0d got=%b exp=%b", n, drained, mq_addr.size() == 0 && !m_req);
      end
      if (ld_hazard !== exp_hz) begin failures++; $display("FAIL rand_hazard n=%0d got=%b exp=%b", n, ld_hazard, exp_hz); end
      if (m_req && mq_addr.size() != 0) begin
        checks++;
        if (mem_addr !== mq_addr[0] || mem_mask !== mq_mask[0] || mem_wdata !== mq_data[0]) begin
          failures++;
          $display("FAIL rand_head n=%0d got=%h/%b/%h exp=%h/%b/%h", n, mem_addr, mem_mask, mem_wdata,
                   mq_addr[0], mq_mask[0], mq_data[0]);
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_simultaneous();
    test_hazard();
    test_zero_mask();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
